// File: rtl/rf_wport_arb_if.sv
// Signal bundle of the GPR write-port arbiter: write-back stage, side unit, regfile port, stall.
// The forwarding lookup signals exist only when RF_WPORT_ARB_FWD_EN is defined.
interface rf_wport_arb_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_waddr;
  logic [DW-1:0] aux_wdata;
  logic          stall_req;
  logic [CW-1:0] fifo_cnt;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RF_WPORT_ARB_FWD_EN
  logic [AW-1:0] fwd_raddr0;
  logic [AW-1:0] fwd_raddr1;
  logic          fwd_hit0;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data0;
  logic [DW-1:0] fwd_data1;
`endif

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, aux_valid, aux_waddr, aux_wdata,
    input  aux_ready, stall_req, fifo_cnt, rf_we, rf_waddr, rf_wdata
`ifdef RF_WPORT_ARB_FWD_EN
    ,
    output fwd_raddr0, fwd_raddr1,
    input  fwd_hit0, fwd_hit1, fwd_data0, fwd_data1
`endif
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, aux_valid, aux_waddr, aux_wdata,
    output aux_ready, stall_req, fifo_cnt, rf_we, rf_waddr, rf_wdata
`ifdef RF_WPORT_ARB_FWD_EN
    ,
    input  fwd_raddr0, fwd_raddr1,
    output fwd_hit0, fwd_hit1, fwd_data0, fwd_data1
`endif
  );
endinterface

// File: rtl/rf_wport_arb.sv
// GPR write-port arbiter: pipeline write-back always wins, side results queue and drain when idle.
// Optional forwarding lookup over queued results and the write register: RF_WPORT_ARB_FWD_EN.
module rf_wport_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  rf_wport_arb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  logic [AW-1:0] mem_addr_r [DEPTH];
  logic [DW-1:0] mem_data_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          aux_ready_r;
  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_nxt_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          rf_we_r;
  logic [AW-1:0] rf_waddr_r;
  logic [DW-1:0] rf_wdata_r;
  logic          rf_we_nxt_s;
  logic [AW-1:0] rf_waddr_nxt_s;
  logic [DW-1:0] rf_wdata_nxt_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;

  // Port grant and FIFO occupancy for this cycle; r0 writes are suppressed, not skipped.
  always_comb begin
    fifo_empty_s   = (cnt_r == CW'(0));
    fifo_full_s    = (cnt_r == FULL_CNT);
    push_s         = bus.aux_valid & aux_ready_r;
    pop_s          = ~bus.pipe_we & ~fifo_empty_s;
    rf_we_nxt_s    = 1'b0;
    rf_waddr_nxt_s = rf_waddr_r;
    rf_wdata_nxt_s = rf_wdata_r;
    if (bus.pipe_we) begin
      rf_we_nxt_s    = (bus.pipe_waddr != AW'(0));
      rf_waddr_nxt_s = bus.pipe_waddr;
      rf_wdata_nxt_s = bus.pipe_wdata;
    end else if (pop_s) begin
      rf_we_nxt_s    = (mem_addr_r[rd_ptr_r] != AW'(0));
      rf_waddr_nxt_s = mem_addr_r[rd_ptr_r];
      rf_wdata_nxt_s = mem_data_r[rd_ptr_r];
    end else begin
      rf_we_nxt_s    = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Starvation count: cycles the queue head loses to the pipeline, saturating.
  always_comb begin
    starve_nxt_s = starve_r;
    if (pop_s || fifo_empty_s) begin
      starve_nxt_s = SW'(0);
    end else if (bus.pipe_we && (starve_r != STARVE_LIM)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Stall FSM: enter drain on starvation or a blocked offer, leave once the queue reads empty.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((starve_nxt_s == STARVE_LIM) || (fifo_full_s && bus.aux_valid)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_r[i] <= AW'(0);
        mem_data_r[i] <= DW'(0);
      end
      rd_ptr_r    <= PW'(0);
      wr_ptr_r    <= PW'(0);
      cnt_r       <= CW'(0);
      aux_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r] <= bus.aux_waddr;
        mem_data_r[wr_ptr_r] <= bus.aux_wdata;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      cnt_r       <= cnt_nxt_s;
      aux_ready_r <= (cnt_nxt_s != FULL_CNT);
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= AW'(0);
      rf_wdata_r <= DW'(0);
    end else begin
      rf_we_r    <= rf_we_nxt_s;
      rf_waddr_r <= rf_waddr_nxt_s;
      rf_wdata_r <= rf_wdata_nxt_s;
    end
  end

  // Starvation counter and stall FSM state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_r <= SW'(0);
      state_r  <= ST_IDLE;
    end else begin
      starve_r <= starve_nxt_s;
      state_r  <= state_nxt_s;
    end
  end

  assign bus.aux_ready = aux_ready_r;
  assign bus.fifo_cnt  = cnt_r;
  assign bus.stall_req = (state_r == ST_DRAIN);
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;

`ifdef RF_WPORT_ARB_FWD_EN
  logic          fwd_hit0_s;
  logic          fwd_hit1_s;
  logic [DW-1:0] fwd_data0_s;
  logic [DW-1:0] fwd_data1_s;
  logic [PW-1:0] fwd_idx_s;
  logic          fwd_vld_s;
  logic          fwd_m0_s;
  logic          fwd_m1_s;

  // Forwarding lookup: write register is oldest, queue scanned head to tail so the youngest match wins.
  always_comb begin
    fwd_m0_s    = rf_we_r && (rf_waddr_r == bus.fwd_raddr0);
    fwd_m1_s    = rf_we_r && (rf_waddr_r == bus.fwd_raddr1);
    fwd_hit0_s  = fwd_m0_s;
    fwd_hit1_s  = fwd_m1_s;
    fwd_data0_s = fwd_m0_s ? rf_wdata_r : DW'(0);
    fwd_data1_s = fwd_m1_s ? rf_wdata_r : DW'(0);
    fwd_idx_s   = rd_ptr_r;
    fwd_vld_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s   = rd_ptr_r + PW'(i);
      fwd_vld_s   = (CW'(i) < cnt_r);
      fwd_m0_s    = fwd_vld_s && (mem_addr_r[fwd_idx_s] == bus.fwd_raddr0);
      fwd_m1_s    = fwd_vld_s && (mem_addr_r[fwd_idx_s] == bus.fwd_raddr1);
      fwd_hit0_s  = fwd_hit0_s | fwd_m0_s;
      fwd_hit1_s  = fwd_hit1_s | fwd_m1_s;
      fwd_data0_s = fwd_m0_s ? mem_data_r[fwd_idx_s] : fwd_data0_s;
      fwd_data1_s = fwd_m1_s ? mem_data_r[fwd_idx_s] : fwd_data1_s;
    end
    fwd_hit0_s = fwd_hit0_s & (bus.fwd_raddr0 != AW'(0));
    fwd_hit1_s = fwd_hit1_s & (bus.fwd_raddr1 != AW'(0));
  end

  assign bus.fwd_hit0  = fwd_hit0_s;
  assign bus.fwd_hit1  = fwd_hit1_s;
  assign bus.fwd_data0 = fwd_data0_s;
  assign bus.fwd_data1 = fwd_data1_s;
`endif
endmodule
